// File: rtl/posit_defines.sv
// Shared constants, decoder state encoding and the unpacked posit bundle
// used by posit_decode_seq and its regime scanner.
package posit_defines;

   localparam int P_NBITS = 32;
   localparam int P_ES    = 2;
   localparam int FBITS   = P_NBITS - P_ES - 3;
   localparam int SCALE_W = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_EMIT = 2'd2
   } dec_state_t;

   typedef struct packed {
      logic               sign;
      logic               zero;
      logic               inf;
      logic [SCALE_W-1:0] scale;
      logic [FBITS-1:0]   fraction;
   } value;

endpackage

// File: rtl/posit_regime_chunk.sv
// Counts leading bits of one regime slice that equal the reference bit and
// flags whether a terminating (differing) bit shows up inside the valid part.
module posit_regime_chunk #(
   parameter  int SCAN_BITS = 4,
   localparam int CW        = $clog2(SCAN_BITS + 1)
) (
   input  logic [SCAN_BITS-1:0] i_slice,
   input  logic                 i_ref,
   input  logic [CW-1:0]        i_nvalid,
   output logic [CW-1:0]        o_count,
   output logic                 o_found
);

   logic w_live;

   // Bits at or beyond i_nvalid lie past the body end and are ignored.
   always_comb begin
      o_count = '0;
      o_found = 1'b0;
      w_live  = 1'b1;
      for (int i = 0; i < SCAN_BITS; i++) begin
         if (w_live && (CW'(i) < i_nvalid)) begin
            if (i_slice[SCAN_BITS-1-i] == i_ref) begin
               o_count = o_count + CW'(1);
            end else begin
               o_found = 1'b1;
               w_live  = 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/posit_decode_seq.sv
// Serial posit decoder: scans the regime SCAN_BITS bits per cycle between an
// input and an output valid/ready handshake. Optional counters: POSIT_DECODE_STATS_EN.
module posit_decode_seq
   import posit_defines::*;
#(
   parameter int NBITS     = P_NBITS,
   parameter int ES        = P_ES,
   parameter int SCAN_BITS = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [NBITS-1:0]     in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_sign,
   output logic [SCALE_W-1:0]   out_scale,
   output logic [NBITS-ES-4:0]  out_fraction,
   output logic                 out_zero,
   output logic                 out_inf,
   output logic [1:0]           dbg_state
`ifdef POSIT_DECODE_STATS_EN
  ,output logic [15:0]          stat_zero_cnt,
   output logic [15:0]          stat_nar_cnt,
   output logic [15:0]          stat_word_cnt
`endif
);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; valid never waits on ready and the payload is held until then.

   localparam int BW    = NBITS - 1;
   localparam int FB    = NBITS - ES - 3;
   localparam int RUN_W = $clog2(NBITS) + 1;
   localparam int CW    = $clog2(SCAN_BITS + 1);

   dec_state_t         r_state, w_state_nxt;
   logic [BW-1:0]      r_body;
   logic [RUN_W-1:0]   r_run;
   value               r_out;

   logic [NBITS-1:0]   w_mag;
   logic [BW-1:0]      w_body;
   logic               w_zero, w_inf;
   logic [BW-1:0]      w_win, w_tail;
   logic [SCAN_BITS-1:0] w_slice;
   logic [RUN_W-1:0]   w_rem, w_run_nxt;
   logic [CW-1:0]      w_nvalid, w_count;
   logic               w_found, w_done;
   logic [ES-1:0]      w_exp;
   logic [FB-1:0]      w_frac;
   logic [SCALE_W-1:0] w_k, w_scale;

   assign w_mag  = in_data[NBITS-1] ? (~in_data + NBITS'(1)) : in_data;
   assign w_body = BW'(w_mag);
   assign w_zero = (in_data == '0);
   assign w_inf  = (in_data == {1'b1, {BW{1'b0}}});

   // The window always starts at the first unscanned body bit.
   assign w_win    = r_body << r_run;
   assign w_slice  = SCAN_BITS'(w_win >> (BW - SCAN_BITS));
   assign w_rem    = RUN_W'(BW) - r_run;
   assign w_nvalid = (w_rem >= RUN_W'(SCAN_BITS)) ? CW'(SCAN_BITS) : CW'(w_rem);

   posit_regime_chunk #(.SCAN_BITS(SCAN_BITS)) u_chunk (
      .i_slice  (w_slice),
      .i_ref    (r_body[BW-1]),
      .i_nvalid (w_nvalid),
      .o_count  (w_count),
      .o_found  (w_found)
   );

   assign w_run_nxt = r_run + RUN_W'(w_count);
   assign w_done    = w_found || (w_run_nxt == RUN_W'(BW));

   // Drop the run and its terminator; shifting in zeros supplies the padding.
   assign w_tail  = r_body << (w_run_nxt + RUN_W'(1));
   assign w_exp   = ES'(w_tail >> (BW - ES));
   assign w_frac  = FB'(w_tail >> (BW - ES - FB));
   assign w_k     = r_body[BW-1] ? (SCALE_W'(w_run_nxt) - SCALE_W'(1))
                                 : (SCALE_W'(0) - SCALE_W'(w_run_nxt));
   assign w_scale = (w_k << ES) + SCALE_W'(w_exp);

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = (w_zero || w_inf) ? S_EMIT : S_SCAN;
         end
         S_SCAN: begin
            if (w_done) w_state_nxt = S_EMIT;
         end
         S_EMIT: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_body <= '0;
         r_run  <= '0;
         r_out  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_body <= w_body;
                  r_run  <= '0;
                  r_out  <= '{sign: in_data[NBITS-1], zero: w_zero, inf: w_inf,
                              scale: '0, fraction: '0};
               end
            end
            S_SCAN: begin
               r_run <= w_run_nxt;
               if (w_done) begin
                  r_out.scale    <= w_scale;
                  r_out.fraction <= w_frac;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_sign     = r_out.sign;
   assign out_scale    = r_out.scale;
   assign out_fraction = r_out.fraction;
   assign out_zero     = r_out.zero;
   assign out_inf      = r_out.inf;
   assign dbg_state    = r_state;

`ifdef POSIT_DECODE_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_zero_cnt <= '0;
         stat_nar_cnt  <= '0;
         stat_word_cnt <= '0;
      end else if (r_state == S_EMIT && out_ready) begin
         if (stat_word_cnt != 16'hFFFF) stat_word_cnt <= stat_word_cnt + 16'd1;
         if (r_out.zero && stat_zero_cnt != 16'hFFFF) stat_zero_cnt <= stat_zero_cnt + 16'd1;
         if (r_out.inf && stat_nar_cnt != 16'hFFFF) stat_nar_cnt <= stat_nar_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_posit_decode_seq.sv
// Self-checking bench for posit_decode_seq: directed test-plan words, random
// words against a bit-serial reference model, backpressure and mid-scan reset.
`timescale 1ns/1ps
module tb_posit_decode_seq;

   localparam int NB = 32;
   localparam int FB = 27;
   localparam int EW = 1 + 8 + FB + 1 + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [NB-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          out_sign;
   logic [7:0]    out_scale;
   logic [FB-1:0] out_fraction;
   logic          out_zero;
   logic          out_inf;
   logic [1:0]    dbg_state;
`ifdef POSIT_DECODE_STATS_EN
   logic [15:0]   stat_zero_cnt, stat_nar_cnt, stat_word_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;
   logic [EW-1:0] exp_q[$];

   posit_decode_seq #(.NBITS(NB), .ES(2), .SCAN_BITS(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_sign     (out_sign),
      .out_scale    (out_scale),
      .out_fraction (out_fraction),
      .out_zero     (out_zero),
      .out_inf      (out_inf),
      .dbg_state    (dbg_state)
`ifdef POSIT_DECODE_STATS_EN
     ,.stat_zero_cnt(stat_zero_cnt),
      .stat_nar_cnt (stat_nar_cnt),
      .stat_word_cnt(stat_word_cnt)
`endif
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [EW-1:0] mk(input logic s, input logic [7:0] sc,
                                        input logic [FB-1:0] f, input logic z, input logic n);
      return {s, sc, f, z, n};
   endfunction

   function automatic logic [EW-1:0] observed();
      return {out_sign, out_scale, out_fraction, out_zero, out_inf};
   endfunction

   // Bit-by-bit reference decode; sc returns the expected number of SCAN cycles.
   function automatic logic [EW-1:0] model(input logic [NB-1:0] w, output int sc);
      logic [NB-1:0] v;
      logic [NB-2:0] b;
      logic [FB-1:0] f;
      logic          r;
      int            run, pos, e, k, sval, lim;
      sc = 0;
      if (w == 32'h0000_0000) return mk(1'b0, 8'd0, '0, 1'b1, 1'b0);
      if (w == 32'h8000_0000) return mk(1'b1, 8'd0, '0, 1'b0, 1'b1);
      v   = w[NB-1] ? -w : w;
      b   = v[NB-2:0];
      r   = b[NB-2];
      run = 0;
      pos = NB - 2;
      while (pos >= 0 && b[pos] == r) begin
         run++;
         pos--;
      end
      pos--;
      e = 0;
      for (int j = 0; j < 2; j++) begin
         e = e * 2 + ((pos >= 0) ? int'(b[pos]) : 0);
         pos--;
      end
      f = '0;
      for (int j = FB - 1; j >= 0; j--) begin
         f[j] = (pos >= 0) ? b[pos] : 1'b0;
         pos--;
      end
      k    = r ? run - 1 : -run;
      sval = k * 4 + e;
      lim  = (run + 1 < NB - 1) ? run + 1 : NB - 1;
      sc   = (lim + 3) / 4;
      return mk(w[NB-1], sval[7:0], f, 1'b0, 1'b0);
   endfunction

   // ---------------- driver ----------------
   task automatic send_word(input logic [NB-1:0] w, input logic [EW-1:0] e,
                            input int sc, input int hold);
      int            n;
      logic [EW-1:0] held, popped;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_wait", {63'd0, in_ready}, 64'd1);
      if (!in_ready) return;
      in_valid = 1'b1;
      in_data  = w;
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = $urandom;
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("latency", 64'(n), 64'(sc));
      if (!out_valid) return;
      held = observed();
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_fields", 64'(observed()), 64'(held));
         check("hold_valid", {63'd0, out_valid}, 64'd1);
         check("hold_in_ready", {63'd0, in_ready}, 64'd0);
      end
      out_ready = 1'b1;
      if (exp_q.size() == 0) begin
         check("queue_nonempty", 64'd0, 64'd1);
         popped = '0;
      end else begin
         popped = exp_q.pop_front();
      end
      check("fields", 64'(observed()), 64'(popped));
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("out_valid_drop", {63'd0, out_valid}, 64'd0);
      check("in_ready_back", {63'd0, in_ready}, 64'd1);
   endtask

   task automatic send_model(input logic [NB-1:0] w, input int hold);
      logic [EW-1:0] e;
      int            sc;
      e = model(w, sc);
      send_word(w, e, sc, hold);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      do_reset();
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_fields", 64'(observed()), 64'd0);
      check("rst_state", {62'd0, dbg_state}, 64'd0);

      send_word(32'h4000_0000, mk(1'b0, 8'd0,   '0, 1'b0, 1'b0), 1, 0);
      send_word(32'h4800_0000, mk(1'b0, 8'd1,   '0, 1'b0, 1'b0), 1, 5);
      send_word(32'hC000_0000, mk(1'b1, 8'd0,   '0, 1'b0, 1'b0), 1, 0);
      send_word(32'h0000_0000, mk(1'b0, 8'd0,   '0, 1'b1, 1'b0), 0, 0);
      send_word(32'h8000_0000, mk(1'b1, 8'd0,   '0, 1'b0, 1'b1), 0, 2);
      send_word(32'h7FFF_FFFF, mk(1'b0, 8'd120, '0, 1'b0, 1'b0), 8, 0);
      send_word(32'h0000_0001, mk(1'b0, 8'h88,  '0, 1'b0, 1'b0), 8, 0);
      send_word(32'h4C00_0000, mk(1'b0, 8'd1, 27'h400_0000, 1'b0, 1'b0), 1, 0);
      send_word(32'hB400_0000, mk(1'b1, 8'd1, 27'h400_0000, 1'b0, 1'b0), 1, 1);

      // Reset while a long regime is still being scanned.
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'h7FFF_FFFF;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_scan_state", {62'd0, dbg_state}, 64'd1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("rst_scan_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_scan_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_scan_fields", 64'(observed()), 64'd0);
      send_word(32'h4800_0000, mk(1'b0, 8'd1, '0, 1'b0, 1'b0), 1, 0);

      for (int i = 0; i < 24; i++) begin
         logic [NB-1:0] w;
         w = $urandom;
         if (i % 6 == 0) w = w >> $urandom_range(24, 31);
         if (i % 6 == 1) w = w | (32'h7FFF_FFF0 >> $urandom_range(0, 4));
         send_model(w, $urandom_range(0, 2));
      end

      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
